forwarding_unit: RTL and testbench
==================================

Name: forwarding_unit

Overview:
- Produces the two 3-bit ALU-operand forwarding selects (ExMux3Select, ExMux4Select) consumed by the execute stage, plus the load-use stall.
- Tracks the destination register, write-enable and result type of each in-flight instruction in an internal 3-deep scoreboard pipeline (EX, MEM, WB).
- Compares each instruction leaving decode against that scoreboard, registers the selects into EX alongside the instruction, and raises stall on a load-use hazard.

Parameters:
- REG_BITS, 3, register-index width (8 architectural registers)
- WB_BYPASS, 1, 1 = forward from the retiring WB value (select 4); 0 = register file is write-through, so select 4 is never generated

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- idValid  in  1  a real instruction is leaving decode this cycle
- idSrc1  in  REG_BITS  operand-1 source register
- idSrc2  in  REG_BITS  operand-2 source register
- idUse1  in  1  operand 1 reads idSrc1 (0 = immediate or unused)
- idUse2  in  1  operand 2 reads idSrc2
- idDest  in  REG_BITS  destination register
- idWrite  in  1  instruction writes idDest
- idType  in  2  result kind: 00 ALU, 01 load, 10 link (PC+1), 11 reserved (treated as ALU)
- flush  in  1  squash the instruction entering EX (branch redirect)
- hold  in  1  global pipeline freeze (memory wait)
- ExMux3Select  out  3  ALU input-1 select, registered
- ExMux4Select  out  3  ALU input-2 select, registered
- stall  out  1  load-use stall request to fetch and decode, combinational

Behaviour:
- Select encoding:
  - 0: no forward (RF or immediate path)
  - 1: EX/MEM ALU result (SignalA)
  - 2: MEM/WB ALU result (SignalB)
  - 3: MEM/WB load data (SignalC)
  - 4: retired WB value (SignalG)
  - 5: EX/MEM PC+1 (SignalI)
  - 6: MEM/WB PC+1 (SignalJ)
  - 7: never driven
- Scoreboard: entries EX, MEM and WB, each holding {valid, dest, write, type}. Each non-hold edge shifts the entries EX→MEM→WB and loads a new EX entry. The old WB entry is discarded.
- Select computation for operand n:
  - Forward only if idUse_n=1 and the matching entry has valid=1 and write=1.
  - Compare idSrc_n against each entry's dest. The youngest match wins, with priority EX > MEM > WB.
  - Match in the current EX entry (it will be in MEM next cycle): ALU→1, link→5. Load cannot occur here because it stalls instead.
  - Match in the current MEM entry: ALU→2, load→3, link→6.
  - Match in the current WB entry: 4 if WB_BYPASS=1, otherwise 0.
  - No match: 0.
- Selects are registered on the edge that moves the instruction into EX, so they are valid for exactly its EX cycle. Latency is 1 cycle from decode.
- stall = idValid & EX.valid & EX.write & EX.type==load & the EX dest matches an idUse-qualified source, gated with ~flush.
- When stall=1 on an edge:
  - New EX entry is a bubble (valid=0).
  - Selects are registered as 0.
  - Decode re-presents the same instruction next cycle.
  - The load is then in MEM, so the stall drops and select 3 is issued. The stall lasts exactly 1 cycle.
- flush=1: new EX entry is a bubble and selects are registered as 0; older entries still shift. flush beats stall.
- hold=1: scoreboard and selects are frozen and stall is forced 0. hold beats flush and stall; a flush asserted during hold is ignored.
- idValid=0 with no stall: a bubble is inserted and selects are registered as 0.
- Both operands reading the same register receive identical selects.
- Reset: all valid bits 0, ExMux3Select=0, ExMux4Select=0, stall=0. Reset takes effect immediately even mid-stall; the first post-reset instruction sees no forwarding.

Test Plan:
- ADD r3 (ALU, dest 3) then a consumer of src1=3, use1=1 → next cycle ExMux3Select=1, ExMux4Select=0.
- LW r2 (load) then a consumer of src2=2 → stall=1 for one cycle with selects 0 (bubble), then ExMux4Select=3 and stall=0.
- r4 written by ADD then by JAL (link) one cycle later, followed by a consumer of r4 → the youngest (JAL, in EX) wins and the select is 5. With one unrelated instruction inserted between, the select is 6.
- Producer of r5 followed by two unrelated instructions, then a consumer of r5 → select 4 with WB_BYPASS=1, and 0 with WB_BYPASS=0.
- LW r1 with flush asserted in the same cycle as the load-use consumer → stall=0 and the EX bubble gets selects 0. With hold=1 for 3 cycles, outputs stay constant and stall=0.
- Reset pulse asserted mid-stall → selects and stall go to 0 asynchronously. A consumer of the old load register afterward gets select 0.

Source files
------------

// File: rtl/forwarding_unit.sv
// Operand forwarding for the execute stage: tracks EX/MEM/WB producers and
// issues registered ALU-input selects plus a combinational load-use stall.
module forwarding_unit #(
  parameter int REG_BITS  = 3,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                idValid,
  input  logic [REG_BITS-1:0] idSrc1,
  input  logic [REG_BITS-1:0] idSrc2,
  input  logic                idUse1,
  input  logic                idUse2,
  input  logic [REG_BITS-1:0] idDest,
  input  logic                idWrite,
  input  logic [1:0]          idType,
  input  logic                flush,
  input  logic                hold,
  output logic [2:0]          ExMux3Select,
  output logic [2:0]          ExMux4Select,
  output logic                stall
);

  localparam logic [1:0] TYPE_LOAD = 2'b01;
  localparam logic [1:0] TYPE_LINK = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] dest;
    logic                write;
    logic [1:0]          kind;
  } entry_t;

  entry_t     ex_r;
  entry_t     mem_r;
  entry_t     wb_r;
  logic [2:0] sel1_s;
  logic [2:0] sel2_s;
  logic       load_hit_s;
  logic       stall_s;
  logic       accept_s;

  // Youngest matching producer wins; a load still in EX never forwards (it stalls).
  function automatic logic [2:0] fwd_select(
    input logic                use_src,
    input logic [REG_BITS-1:0] src,
    input entry_t              ex,
    input entry_t              mem,
    input entry_t              wb
  );
    logic [2:0] sel;
    sel = 3'd0;
    if (!use_src) begin
      sel = 3'd0;
    end else if (ex.valid && ex.write && (ex.dest == src)) begin
      case (ex.kind)
        TYPE_LINK: sel = 3'd5;
        TYPE_LOAD: sel = 3'd0;
        default:   sel = 3'd1;
      endcase
    end else if (mem.valid && mem.write && (mem.dest == src)) begin
      case (mem.kind)
        TYPE_LINK: sel = 3'd6;
        TYPE_LOAD: sel = 3'd3;
        default:   sel = 3'd2;
      endcase
    end else if (wb.valid && wb.write && (wb.dest == src)) begin
      sel = WB_BYPASS ? 3'd4 : 3'd0;
    end else begin
      sel = 3'd0;
    end
    return sel;
  endfunction

  // Hazard detection and select computation for the instruction leaving decode.
  always_comb begin
    sel1_s     = fwd_select(idUse1, idSrc1, ex_r, mem_r, wb_r);
    sel2_s     = fwd_select(idUse2, idSrc2, ex_r, mem_r, wb_r);
    load_hit_s = (idUse1 && (idSrc1 == ex_r.dest)) || (idUse2 && (idSrc2 == ex_r.dest));
    stall_s    = idValid && ex_r.valid && ex_r.write && (ex_r.kind == TYPE_LOAD) &&
                 load_hit_s && !flush && !hold;
    accept_s   = idValid && !stall_s && !flush;
  end

  assign stall = stall_s;

  // Scoreboard shift and registered selects; hold freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_r         <= '0;
      mem_r        <= '0;
      wb_r         <= '0;
      ExMux3Select <= 3'd0;
      ExMux4Select <= 3'd0;
    end else if (!hold) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (accept_s) begin
        ex_r.valid   <= 1'b1;
        ex_r.dest    <= idDest;
        ex_r.write   <= idWrite;
        ex_r.kind    <= idType;
        ExMux3Select <= sel1_s;
        ExMux4Select <= sel2_s;
      end else begin
        ex_r         <= '0;
        ExMux3Select <= 3'd0;
        ExMux4Select <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Randomized scoreboard bench for forwarding_unit, run on a WB-bypass and a
// write-through instance side by side against an age-indexed reference model.
module tb_forwarding_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use1, id_use2, id_write, flush, hold;
  logic [2:0] id_src1, id_src2, id_dest;
  logic [1:0] id_type;
  logic [2:0] s3_b, s4_b, s3_n, s4_n;
  logic       stall_b, stall_n;

  always #5 clk = ~clk;

  forwarding_unit #(.REG_BITS(3), .WB_BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .idValid(id_valid), .idSrc1(id_src1), .idSrc2(id_src2),
    .idUse1(id_use1), .idUse2(id_use2), .idDest(id_dest), .idWrite(id_write),
    .idType(id_type), .flush(flush), .hold(hold),
    .ExMux3Select(s3_b), .ExMux4Select(s4_b), .stall(stall_b));

  forwarding_unit #(.REG_BITS(3), .WB_BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .idValid(id_valid), .idSrc1(id_src1), .idSrc2(id_src2),
    .idUse1(id_use1), .idUse2(id_use2), .idDest(id_dest), .idWrite(id_write),
    .idType(id_type), .flush(flush), .hold(hold),
    .ExMux3Select(s3_n), .ExMux4Select(s4_n), .stall(stall_n));

  typedef struct {
    int sel3_b;
    int sel4_b;
    int sel3_n;
    int sel4_n;
    int stall;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: in-flight producers indexed by age (0 = EX, 1 = MEM, 2 = WB).
  bit mv[3];
  int md[3];
  bit mw[3];
  int mt[3];
  int ms3_b, ms4_b, ms3_n, ms4_n;
  bit last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int ref_sel(input bit use_src, input int src, input bit byp);
    if (!use_src) return 0;
    for (int a = 0; a < 3; a++) begin
      if (mv[a] && mw[a] && md[a] == src) begin
        if (a == 0) return (mt[a] == 2) ? 5 : (mt[a] == 1) ? 0 : 1;
        if (a == 1) return (mt[a] == 2) ? 6 : (mt[a] == 1) ? 3 : 2;
        return byp ? 4 : 0;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      mv[a] = 1'b0; md[a] = 0; mw[a] = 1'b0; mt[a] = 0;
    end
    ms3_b = 0; ms4_b = 0; ms3_n = 0; ms4_n = 0;
    last_stall = 1'b0;
  endtask

  task automatic drive(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int d, input bit w, input int t, input bit f, input bit h);
    exp_t e;
    bit   st, acc;
    int   n3b, n4b, n3n, n4n;
    @(posedge clk);
    #1;
    id_valid = v; id_src1 = s1[2:0]; id_use1 = u1; id_src2 = s2[2:0]; id_use2 = u2;
    id_dest = d[2:0]; id_write = w; id_type = t[1:0]; flush = f; hold = h;
    st = !h && !f && v && mv[0] && mw[0] && mt[0] == 1 &&
         ((u1 && s1 == md[0]) || (u2 && s2 == md[0]));
    e.sel3_b = ms3_b; e.sel4_b = ms4_b; e.sel3_n = ms3_n; e.sel4_n = ms4_n; e.stall = st;
    exp_q.push_back(e);
    last_stall = st;
    if (!h) begin
      acc = v && !st && !f;
      n3b = acc ? ref_sel(u1, s1, 1'b1) : 0;
      n4b = acc ? ref_sel(u2, s2, 1'b1) : 0;
      n3n = acc ? ref_sel(u1, s1, 1'b0) : 0;
      n4n = acc ? ref_sel(u2, s2, 1'b0) : 0;
      for (int a = 2; a > 0; a--) begin
        mv[a] = mv[a-1]; md[a] = md[a-1]; mw[a] = mw[a-1]; mt[a] = mt[a-1];
      end
      mv[0] = acc; md[0] = d; mw[0] = w; mt[0] = t;
      ms3_b = n3b; ms4_b = n4b; ms3_n = n3n; ms4_n = n4n;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents selects and stall; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel3_bypass", 32'(s3_b), e.sel3_b);
      chk("sel4_bypass", 32'(s4_b), e.sel4_b);
      chk("sel3_wthru", 32'(s3_n), e.sel3_n);
      chk("sel4_wthru", 32'(s4_n), e.sel4_n);
      chk("stall_bypass", 32'(stall_b), e.stall);
      chk("stall_wthru", 32'(stall_n), e.stall);
    end
  end

  initial begin
    int s1, s2, d, t;
    bit v, u1, u2, w, f, h;
    reset = 1'b1;
    id_valid = 1'b0; id_src1 = 3'd0; id_src2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    id_dest = 3'd0; id_write = 1'b0; id_type = 2'd0; flush = 1'b0; hold = 1'b0;
    model_reset();
    #2;
    chk("reset_sel3", 32'(s3_b), 32'd0);
    chk("reset_sel4", 32'(s4_b), 32'd0);
    chk("reset_stall", 32'(stall_b), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // ALU producer then consumer in EX
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 1, 1, 1, 7, 1, 0, 0, 0);
    idle(3);
    // Load-use: stall, then re-present and get select 3
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    drive(1, 6, 1, 2, 1, 6, 1, 0, 0, 0);
    drive(1, 6, 1, 2, 1, 6, 1, 0, 0, 0);
    idle(3);
    // ADD r4, JAL r4, consumer -> 5; with a gap -> 6
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 4, 1, 2, 0, 0);
    drive(1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 4, 1, 2, 0, 0);
    drive(1, 1, 1, 1, 1, 6, 1, 0, 0, 0);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // WB producer -> 4 (bypass) / 0 (write-through)
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0, 0);
    idle(3);
    // Flush beats stall, then hold freezes for 3 cycles
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0, 2, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 1, 3, 1, 1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 1, 0, 0, 0, 1, 1);
    drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset in the middle of a load-use stall
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 1, 1, 1, 0, 0);
    @(posedge clk); #1;
    id_valid = 1'b1; id_src1 = 3'd1; id_use1 = 1'b1; id_src2 = 3'd0; id_use2 = 1'b0;
    id_dest = 3'd2; id_write = 1'b1; id_type = 2'd0; flush = 1'b0; hold = 1'b0;
    #1;
    chk("pre_reset_stall", 32'(stall_b), 32'd1);
    chk("pre_reset_sel3", 32'(s3_b), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_stall", 32'(stall_b), 32'd0);
    chk("async_reset_sel3", 32'(s3_b), 32'd0);
    chk("async_reset_sel3_wthru", 32'(s3_n), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    id_valid = 1'b0;
    model_reset();
    drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic; a stalled instruction is re-presented unchanged
    s1 = 0; s2 = 0; d = 0; t = 0; v = 0; u1 = 0; u2 = 0; w = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        v  = ($urandom_range(9, 0) != 0);
        s1 = $urandom_range(3, 0); s2 = $urandom_range(3, 0); d = $urandom_range(3, 0);
        u1 = ($urandom_range(3, 0) != 0); u2 = ($urandom_range(3, 0) != 0);
        w  = ($urandom_range(4, 0) != 0); t = $urandom_range(3, 0);
      end
      f = ($urandom_range(9, 0) == 0);
      h = ($urandom_range(9, 0) == 0);
      drive(v, s1, u1, s2, u2, d, w, t, f, h);
    end
    idle(2);
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
